// File: rtl/gol_mon_pkg.sv
// Shared types and encodings for the Game of Life board monitor.
// Optional period-2 detection is enabled by defining GOL_MON_PERIOD2_EN.
package gol_mon_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRACK = 2'd1,
        DUMP  = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam int unsigned ST_W       = 3;
    localparam int unsigned ST_EXTINCT = 0;
    localparam int unsigned ST_CYCLE   = 1;
    localparam int unsigned ST_MAXGEN  = 2;

    localparam int unsigned PER_W = 2;
    localparam logic [PER_W-1:0] PER_NONE  = 2'd0;
    localparam logic [PER_W-1:0] PER_STILL = 2'd1;
    localparam logic [PER_W-1:0] PER_P2    = 2'd2;

endpackage

// File: rtl/gol_popcount.sv
// Combinational population count of a W-bit vector.
module gol_popcount #(
    parameter int unsigned W = 24
) (
    input  logic [W-1:0]           i_vec,
    output logic [$clog2(W+1)-1:0] o_count_c
);

    localparam int unsigned CW = $clog2(W+1);

    always_comb begin
        o_count_c = '0;
        for (int i = 0; i < int'(W); i++) begin
            o_count_c = o_count_c + CW'(i_vec[i]);
        end
    end

endmodule

// File: rtl/gol_board_monitor.sv
// Game of Life run monitor: counts generations, detects termination and streams the final board.
// Define GOL_MON_PERIOD2_EN to add the prev2 register and period-2 oscillation detection.
module gol_board_monitor
    import gol_mon_pkg::*;
#(
    parameter int unsigned ROW     = 4,
    parameter int unsigned COL     = 6,
    parameter int unsigned MAX_GEN = 1000,
    parameter int unsigned GEN_W   = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [ROW*COL-1:0]            game_board,
    input  logic                          game_board_initialized,
    output logic                          halt,
    output logic [2:0]                    status,
    output logic [1:0]                    period,
    output logic [GEN_W-1:0]              gen_count,
    output logic [$clog2(ROW*COL+1)-1:0]  population,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [COL-1:0]                out_row,
    output logic [$clog2(ROW)-1:0]        out_row_idx,
    output logic                          out_last
);

    localparam int unsigned N      = ROW * COL;
    localparam int unsigned POP_W  = $clog2(N + 1);
    localparam int unsigned RIDX_W = $clog2(ROW);

    state_e              r_state, w_state_nx;
    logic [N-1:0]        r_prev, w_prev_nx;
    logic [N-1:0]        r_snapshot, w_snapshot_nx;
`ifdef GOL_MON_PERIOD2_EN
    logic [N-1:0]        r_prev2, w_prev2_nx;
`endif
    logic [GEN_W-1:0]    r_gen, w_gen_nx;
    logic [POP_W-1:0]    r_pop, w_pop_nx;
    logic                r_halt, w_halt_nx;
    logic [ST_W-1:0]     r_status, w_status_nx;
    logic [PER_W-1:0]    r_period, w_period_nx;
    logic                r_valid, w_valid_nx;
    logic [RIDX_W-1:0]   r_row_idx, w_row_idx_nx;
    logic [COL-1:0]      r_row, w_row_nx;
    logic                r_last, w_last_nx;

    logic [POP_W-1:0]    w_pop_board;
    logic [GEN_W:0]      w_gen_inc;
    logic [RIDX_W-1:0]   w_idx_inc;
    logic                w_extinct, w_still, w_p2, w_maxgen, w_hit;

    gol_popcount #(.W(N)) u_popcount (
        .i_vec     (game_board),
        .o_count_c (w_pop_board)
    );

    function automatic logic [COL-1:0] snap_row(input logic [N-1:0] b, input logic [RIDX_W-1:0] r);
        return b[int'(r)*COL +: COL];
    endfunction

    // Termination conditions on the sampled board, in priority order below.
    assign w_gen_inc = {1'b0, r_gen} + (GEN_W+1)'(1);
    assign w_extinct = (game_board == '0);
    assign w_still   = (game_board == r_prev);
`ifdef GOL_MON_PERIOD2_EN
    assign w_p2      = (r_gen != '0) && (game_board == r_prev2);
`else
    assign w_p2      = 1'b0;
`endif
    assign w_maxgen  = (w_gen_inc == (GEN_W+1)'(MAX_GEN));
    assign w_hit     = w_extinct || w_still || w_p2 || w_maxgen;
    assign w_idx_inc = r_row_idx + RIDX_W'(1);

    always_comb begin
        w_state_nx    = r_state;
        w_prev_nx     = r_prev;
        w_snapshot_nx = r_snapshot;
`ifdef GOL_MON_PERIOD2_EN
        w_prev2_nx    = r_prev2;
`endif
        w_gen_nx      = r_gen;
        w_pop_nx      = r_pop;
        w_halt_nx     = r_halt;
        w_status_nx   = r_status;
        w_period_nx   = r_period;
        w_valid_nx    = r_valid;
        w_row_idx_nx  = r_row_idx;
        w_row_nx      = r_row;
        w_last_nx     = r_last;

        case (r_state)
            IDLE: begin
                if (start && game_board_initialized) begin
                    w_prev_nx  = game_board;
                    w_gen_nx   = '0;
                    w_pop_nx   = w_pop_board;
                    w_state_nx = TRACK;
                end
            end
            TRACK: begin
`ifdef GOL_MON_PERIOD2_EN
                w_prev2_nx = r_prev;
`endif
                w_prev_nx = game_board;
                w_gen_nx  = (r_gen >= GEN_W'(MAX_GEN)) ? r_gen : w_gen_inc[GEN_W-1:0];
                w_pop_nx  = w_pop_board;
                // An empty board equals an empty prev, so extinct must win over still.
                if (w_extinct) begin
                    w_status_nx[ST_EXTINCT] = 1'b1;
                end else if (w_still) begin
                    w_status_nx[ST_CYCLE] = 1'b1;
                    w_period_nx           = PER_STILL;
                end else if (w_p2) begin
                    w_status_nx[ST_CYCLE] = 1'b1;
                    w_period_nx           = PER_P2;
                end else if (w_maxgen) begin
                    w_status_nx[ST_MAXGEN] = 1'b1;
                end
                if (w_hit) begin
                    w_snapshot_nx = game_board;
                    w_halt_nx     = 1'b1;
                    w_state_nx    = DUMP;
                end
            end
            DUMP: begin
                if (!r_valid) begin
                    w_valid_nx   = 1'b1;
                    w_row_idx_nx = '0;
                    w_row_nx     = snap_row(r_snapshot, '0);
                    w_last_nx    = (ROW == 1);
                end else if (out_ready) begin
                    if (r_last) begin
                        w_valid_nx = 1'b0;
                        w_state_nx = DONE;
                    end else begin
                        w_row_idx_nx = w_idx_inc;
                        w_row_nx     = snap_row(r_snapshot, w_idx_inc);
                        w_last_nx    = (w_idx_inc == RIDX_W'(ROW - 1));
                    end
                end
            end
            DONE: begin
            end
            default: w_state_nx = IDLE;
        endcase

        // Dropping the run enable abandons everything and returns to reset values.
        if (!start) begin
            w_state_nx    = IDLE;
            w_prev_nx     = '0;
            w_snapshot_nx = '0;
`ifdef GOL_MON_PERIOD2_EN
            w_prev2_nx    = '0;
`endif
            w_gen_nx      = '0;
            w_pop_nx      = '0;
            w_halt_nx     = 1'b0;
            w_status_nx   = '0;
            w_period_nx   = PER_NONE;
            w_valid_nx    = 1'b0;
            w_row_idx_nx  = '0;
            w_row_nx      = '0;
            w_last_nx     = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_prev     <= '0;
            r_snapshot <= '0;
`ifdef GOL_MON_PERIOD2_EN
            r_prev2    <= '0;
`endif
            r_gen      <= '0;
            r_pop      <= '0;
            r_halt     <= 1'b0;
            r_status   <= '0;
            r_period   <= PER_NONE;
            r_valid    <= 1'b0;
            r_row_idx  <= '0;
            r_row      <= '0;
            r_last     <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_prev     <= w_prev_nx;
            r_snapshot <= w_snapshot_nx;
`ifdef GOL_MON_PERIOD2_EN
            r_prev2    <= w_prev2_nx;
`endif
            r_gen      <= w_gen_nx;
            r_pop      <= w_pop_nx;
            r_halt     <= w_halt_nx;
            r_status   <= w_status_nx;
            r_period   <= w_period_nx;
            r_valid    <= w_valid_nx;
            r_row_idx  <= w_row_idx_nx;
            r_row      <= w_row_nx;
            r_last     <= w_last_nx;
        end
    end

    assign halt        = r_halt;
    assign status      = r_status;
    assign period      = r_period;
    assign gen_count   = r_gen;
    assign population  = r_pop;
    assign out_valid   = r_valid;
    assign out_row     = r_row;
    assign out_row_idx = r_row_idx;
    assign out_last    = r_last;

endmodule

// File: tb/tb_gol_board_monitor.sv
// Scoreboard bench for gol_board_monitor; a reference model predicts termination and snapshot rows.
module tb_gol_board_monitor;

    localparam int unsigned ROW     = 4;
    localparam int unsigned COL     = 6;
    localparam int unsigned N       = ROW * COL;
    localparam int unsigned MAX_GEN = 5;
    localparam int unsigned GEN_W   = 16;
    localparam int unsigned POP_W   = $clog2(N + 1);
    localparam int unsigned RIDX_W  = $clog2(ROW);
    localparam int          BUDGET  = 60;

    localparam logic [N-1:0] BLINK_H = 24'h000380;
    localparam logic [N-1:0] BLINK_V = 24'h004104;
    localparam logic [N-1:0] BLOCK   = 24'h0000C3;
    localparam logic [N-1:0] SINGLE  = 24'h000100;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic [N-1:0]      game_board;
    logic              game_board_initialized;
    logic              halt;
    logic [2:0]        status;
    logic [1:0]        period;
    logic [GEN_W-1:0]  gen_count;
    logic [POP_W-1:0]  population;
    logic              out_valid;
    logic              out_ready;
    logic [COL-1:0]    out_row;
    logic [RIDX_W-1:0] out_row_idx;
    logic              out_last;

    gol_board_monitor #(
        .ROW(ROW), .COL(COL), .MAX_GEN(MAX_GEN), .GEN_W(GEN_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .game_board(game_board), .game_board_initialized(game_board_initialized),
        .halt(halt), .status(status), .period(period),
        .gen_count(gen_count), .population(population),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_row(out_row), .out_row_idx(out_row_idx), .out_last(out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0]      gen;
        logic [2:0]       status;
        logic [1:0]       period;
        logic [POP_W-1:0] pop;
    } res_t;

    typedef struct packed {
        logic [RIDX_W-1:0] idx;
        logic [COL-1:0]    row;
        logic              last;
    } row_t;

    res_t         exp_q[$];
    row_t         row_q[$];
    logic [N-1:0] seq[$];
    int           n_tests = 0;
    int           n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: walk the board sequence and queue the terminating result and its rows.
    task automatic predict();
        logic [N-1:0] prev, prev2, b;
        logic [2:0]   st;
        logic [1:0]   per;
        prev  = seq[0];
        prev2 = '0;
        for (int g = 1; g < seq.size(); g++) begin
            b   = seq[g];
            st  = 3'b000;
            per = 2'd0;
            if (b == '0) st = 3'b001;
            else if (b == prev) begin st = 3'b010; per = 2'd1; end
`ifdef GOL_MON_PERIOD2_EN
            else if (g >= 2 && b == prev2) begin st = 3'b010; per = 2'd2; end
`endif
            else if (g == int'(MAX_GEN)) st = 3'b100;
            if (st != 3'b000) begin
                exp_q.push_back('{gen: 32'(g), status: st, period: per, pop: POP_W'($countones(b))});
                for (int r = 0; r < int'(ROW); r++) begin
                    logic [COL-1:0] rb;
                    rb = b[r*COL +: COL];
                    row_q.push_back('{idx: RIDX_W'(r), row: rb, last: (r == int'(ROW) - 1)});
                end
                return;
            end
            prev2 = prev;
            prev  = b;
        end
    endtask

    task automatic check_idle(input string tag);
        check_eq({tag, "_halt"},   32'(halt), 0);
        check_eq({tag, "_status"}, 32'(status), 0);
        check_eq({tag, "_period"}, 32'(period), 0);
        check_eq({tag, "_gen"},    32'(gen_count), 0);
        check_eq({tag, "_pop"},    32'(population), 0);
        check_eq({tag, "_valid"},  32'(out_valid), 0);
        check_eq({tag, "_rowbus"}, 32'({out_row_idx, out_row, out_last}), 0);
    endtask

    // Drive seq one generation per cycle, check tracking, halt, dump and the final DONE hold.
    task automatic run(input string tag, input int ready_mode, input int rst_after);
        int   cyc, halt_cyc, xfers;
        bit   seen, fin, last_sent, held;
        row_t hold_row, er;
        res_t e;
        exp_q.delete();
        row_q.delete();
        predict();
        seen = 0; fin = 0; last_sent = 0; held = 0;
        xfers = 0; halt_cyc = 0; cyc = 0;
        e = '0; hold_row = '0;
        start = 1'b1;
        game_board_initialized = 1'b1;
        game_board = seq[0];
        out_ready = (ready_mode == 0);
        while (cyc < BUDGET && !fin) begin
            @(posedge clk);
            #1;
            cyc++;
            game_board = (cyc < seq.size()) ? seq[cyc] : N'($urandom);
            if (!seen) begin
                if (halt) begin
                    seen = 1; halt_cyc = cyc;
                    if (exp_q.size() == 0) begin
                        check_eq({tag, "_unexpected_halt"}, 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check_eq({tag, "_halt_gen"},    32'(gen_count), e.gen);
                        check_eq({tag, "_halt_status"}, 32'(status), 32'(e.status));
                        check_eq({tag, "_halt_period"}, 32'(period), 32'(e.period));
                        check_eq({tag, "_halt_pop"},    32'(population), 32'(e.pop));
                        check_eq({tag, "_valid_lag"},   32'(out_valid), 0);
                    end
                end else if (cyc - 1 < seq.size()) begin
                    check_eq({tag, "_trk_gen"}, 32'(gen_count), 32'(cyc - 1));
                    check_eq({tag, "_trk_pop"}, 32'(population), 32'($countones(seq[cyc-1])));
                end
            end else if (last_sent) begin
                check_eq({tag, "_done_valid"},  32'(out_valid), 0);
                check_eq({tag, "_done_halt"},   32'(halt), 1);
                check_eq({tag, "_done_gen"},    32'(gen_count), e.gen);
                check_eq({tag, "_done_status"}, 32'(status), 32'(e.status));
                fin = 1;
            end else begin
                if (cyc == halt_cyc + 1) check_eq({tag, "_valid_rise"}, 32'(out_valid), 1);
                if (held) begin
                    check_eq({tag, "_stall_hold"}, 32'({out_valid, out_row_idx, out_row}),
                             32'({1'b1, hold_row.idx, hold_row.row}));
                    held = 0;
                end
                case (ready_mode)
                    0:       out_ready = 1'b1;
                    1:       out_ready = ((cyc - halt_cyc - 1) % 3 == 0);
                    default: out_ready = 1'($urandom_range(0, 1));
                endcase
                if (rst_after >= 0 && xfers == rst_after && out_valid) begin
                    rst_n = 1'b0;
                    #1;
                    check_idle({tag, "_rst"});
                    start = 1'b0;
                    out_ready = 1'b0;
                    row_q.delete();
                    @(posedge clk);
                    #1;
                    rst_n = 1'b1;
                    check_idle({tag, "_rst_rel"});
                    return;
                end
                if (out_valid && out_ready) begin
                    xfers++;
                    if (row_q.size() == 0) begin
                        check_eq({tag, "_extra_row"}, 1, 0);
                    end else begin
                        er = row_q.pop_front();
                        check_eq({tag, "_row"}, 32'({out_row_idx, out_row, out_last}),
                                 32'({er.idx, er.row, er.last}));
                        last_sent = er.last;
                    end
                end else if (out_valid) begin
                    held = 1;
                    hold_row = '{idx: out_row_idx, row: out_row, last: out_last};
                end
            end
        end
        check_eq({tag, "_finished"}, 32'(fin), 1);
        check_eq({tag, "_xfers"}, 32'(xfers), ROW);
        out_ready = 1'b0;
        start = 1'b0;
        @(posedge clk);
        #1;
        check_idle({tag, "_drop"});
    endtask

    task automatic abort_track();
        seq = '{24'h0F0001, 24'h00A0A0, 24'h300C00, 24'h0F0001, 24'h00A0A0, 24'h300C00};
        start = 1'b1;
        game_board_initialized = 1'b0;
        game_board = seq[0];
        @(posedge clk);
        #1;
        check_eq("noinit_pop", 32'(population), 0);
        game_board_initialized = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk);
            #1;
            check_eq("abort_gen", 32'(gen_count), 32'(k - 1));
            game_board = seq[k];
        end
        check_eq("abort_halt", 32'(halt), 0);
        start = 1'b0;
        @(posedge clk);
        #1;
        check_idle("abort_trk");
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        game_board_initialized = 1'b0;
        game_board = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_idle("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        seq = '{BLINK_H, BLINK_V, BLINK_H, BLINK_V, BLINK_H, BLINK_V, BLINK_H, BLINK_V};
        run("blinker", 0, -1);

        seq = '{BLOCK, BLOCK, BLOCK, BLOCK};
        run("block", 0, -1);

        seq = '{SINGLE, 24'h0, 24'h0};
        run("single", 0, -1);

        seq = '{BLOCK, BLOCK, BLOCK, BLOCK};
        run("stall", 1, -1);

        abort_track();

        seq = '{BLOCK, BLOCK, BLOCK, BLOCK};
        run("restart", 0, -1);

        seq = '{BLOCK, BLOCK, BLOCK, BLOCK};
        run("rst_dump", 1, 2);

        seq.delete();
        for (int i = 0; i < 8; i++) seq.push_back(N'($urandom) | N'(1 << i));
        run("random", 2, -1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
